score_digit_renderer: RTL and testbench
=======================================

// Module: score_digit_renderer
// PURPOSE
//  Upstream feeder for the score-digit palette stage. Latches a binary score and converts it
//  to 4 BCD digits with a sequential double-dabble. Per pixel it maps DrawX/DrawY onto the
//  4-digit score box and drives the digit glyph ROM. It registers the ROM's 4-bit colour index
//  as palette_index, with a draw enable (score_on) aligned to that index.
// PARAMETERS
//  SCORE_X   560  left pixel column of score box (digit 0 = most significant)
//  SCORE_Y   16   top pixel row of score box
//  DIGIT_W   16   glyph width in pixels; must be a power of 2
//  DIGIT_H   24   glyph height in pixels
//  ADDR_W    9    glyph ROM address width; must satisfy 2**ADDR_W >= DIGIT_W*DIGIT_H
// PORTS
//  Clk            in   1       system/pixel clock
//  Reset          in   1       synchronous, active-high reset
//  score_in       in   14      binary score, unsigned
//  score_load     in   1       1-cycle strobe: sample score_in
//  busy           out  1       conversion/commit in progress
//  bcd_digits     out  16      displayed digits, [15:12] = thousands ... [3:0] = ones
//  DrawX          in   10      current pixel column
//  DrawY          in   10      current pixel row
//  rom_addr       out  ADDR_W  glyph ROM address = ly*DIGIT_W + lx
//  rom_digit      out  4       glyph select (0-9) for the glyph ROM
//  rom_index      in   4       glyph ROM data, valid 1 cycle after rom_addr/rom_digit
//  palette_index  out  4       colour index to palette stage
//  score_on       out  1       1 = palette_index is a score pixel this cycle
// BEHAVIOUR
//  Reset: FSM=IDLE, pending=0, busy=0, bcd_digits=16'h0000, rom_addr=0, rom_digit=0,
//   palette_index=0, score_on=0. Pipeline valid flags are cleared.
//   Reset mid-conversion aborts the conversion. Display is 0.
//  Conversion FSM: IDLE -> SHIFT -> COMMIT_WAIT -> IDLE.
//   IDLE: score_load=1 latches min(score_in, 9999) into the shift register and clears the
//    BCD accumulator. Next state SHIFT, iteration count=0.
//   SHIFT: one iteration per cycle. Each accumulator nibble >=5 gets +3, then
//    {bcd,bin} shifts left 1. After exactly 14 iterations go to COMMIT_WAIT.
//   COMMIT_WAIT: if DrawY is inside [SCORE_Y, SCORE_Y+DIGIT_H), hold (no tearing).
//    Otherwise copy the accumulator to bcd_digits on that edge and go to IDLE.
//   busy=1 in SHIFT and COMMIT_WAIT.
//   Unblocked latency: load sampled at edge t; bcd_digits updates and busy=0 at edge t+16.
//   score_load while busy: latch the value into a 1-deep pending register (newest wins).
//    On the commit edge, if pending is set, start a new conversion from pending
//    (busy stays 1) and clear pending.
//   score_load on the same edge as commit: that value is taken as the new conversion.
//  Pixel pipeline (2-cycle latency, DrawX/DrawY at cycle n -> palette_index/score_on at n+2):
//   S1 (edge n+1): in_box = SCORE_X<=DrawX<SCORE_X+4*DIGIT_W && SCORE_Y<=DrawY<SCORE_Y+DIGIT_H.
//    Compute slot=(DrawX-SCORE_X)>>log2(DIGIT_W), lx = low bits, ly=DrawY-SCORE_Y.
//    Register rom_addr, rom_digit=bcd_digits nibble for slot, vis1=in_box && !blank.
//    Outside the box: rom_addr=0, rom_digit=0, vis1=0.
//   Leading-zero blanking: slots left of the first nonzero digit are blank. Slot 3 (ones)
//    is never blank, so a score of 0 shows "0".
//   S2 (edge n+2): palette_index = vis1 ? rom_index : 0; score_on = vis1.
//   Pipeline runs every cycle regardless of FSM state. Digits only change on a commit edge.
//  Arithmetic: unsigned. DrawX-SCORE_X is computed only when DrawX>=SCORE_X (no wrap).
//   Inputs above 9999 (up to 16383) saturate to 9999.
// TESTING
//  Reset, then scan the box -> only slot 3 lit, rom_digit=0; slots 0-2 score_on=0.
//  Load 1234 with DrawY=200 -> busy 1 for 16 cycles; then bcd_digits=16'h1234, busy=0.
//  Load 16000 -> bcd_digits=16'h9999. Load 70 -> 16'h0070; slots 0,1 blanked.
//  Load 5 while DrawY=20 (in box) -> busy holds until DrawY=40; commit edge sets 16'h0005.
//  Load 11, then 22 and 33 while busy -> final bcd_digits=16'h0033; 22 is never displayed.
//  Drive DrawX=SCORE_X+17, DrawY=SCORE_Y+2 with score 1234 -> rom_digit=2, rom_addr=33
//   next cycle; palette_index=rom_index and score_on=1 two cycles after.

Source files
------------

// File: rtl/score_digit_renderer.sv
// Score digit renderer: binary score -> BCD (sequential double-dabble) and
// per-pixel glyph ROM addressing for a 4-digit score box, 2-cycle pixel pipeline.
module score_digit_renderer #(
    parameter int unsigned SCORE_X = 560,
    parameter int unsigned SCORE_Y = 16,
    parameter int unsigned DIGIT_W = 16,
    parameter int unsigned DIGIT_H = 24,
    parameter int unsigned ADDR_W  = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [13:0]       score_in,
    input  logic              score_load,
    output logic              busy,
    output logic [15:0]       bcd_digits,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        rom_digit,
    input  logic [3:0]        rom_index,
    output logic [3:0]        palette_index,
    output logic              score_on
);

    localparam int unsigned LX_W      = $clog2(DIGIT_W);
    localparam logic [9:0]  X_LO      = 10'(SCORE_X);
    localparam logic [9:0]  X_HI      = 10'(SCORE_X + 4 * DIGIT_W);
    localparam logic [9:0]  Y_LO      = 10'(SCORE_Y);
    localparam logic [9:0]  Y_HI      = 10'(SCORE_Y + DIGIT_H);
    localparam logic [13:0] SCORE_MAX = 14'd9999;
    localparam logic [3:0]  ITER_LAST = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SHIFT       = 2'd1,
        ST_COMMIT_WAIT = 2'd2
    } state_t;

    // Conversion state
    state_t      r_state;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [13:0] r_pend_val;
    logic        r_pend_vld;
    logic        r_busy;
    logic [15:0] r_digits;

    // Pixel pipeline state
    logic [ADDR_W-1:0] r_rom_addr;
    logic [3:0]        r_rom_digit;
    logic              r_vis1;
    logic [3:0]        r_palette;
    logic              r_score_on;

    logic [13:0]       w_load_val;
    logic [15:0]       w_bcd_adj;
    logic              w_x_ge;
    logic              w_y_ge;
    logic              w_x_in_box;
    logic              w_y_in_box;
    logic              w_in_box;
    logic [9:0]        w_dx;
    logic [9:0]        w_ly;
    logic [1:0]        w_slot;
    logic [LX_W-1:0]   w_lx;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_lead_blank;
    logic              w_blank;
    logic [3:0]        w_digit;

    // Saturate incoming score to the 4-digit display range
    assign w_load_val = (score_in > SCORE_MAX) ? SCORE_MAX : score_in;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Box geometry; offsets only formed when the coordinate is past the box origin
    assign w_x_ge     = (DrawX >= X_LO);
    assign w_y_ge     = (DrawY >= Y_LO);
    assign w_x_in_box = w_x_ge && (DrawX < X_HI);
    assign w_y_in_box = w_y_ge && (DrawY < Y_HI);
    assign w_in_box   = w_x_in_box && w_y_in_box;
    assign w_dx       = w_x_ge ? (DrawX - X_LO) : 10'd0;
    assign w_ly       = w_y_ge ? (DrawY - Y_LO) : 10'd0;
    assign w_slot     = 2'(w_dx >> LX_W);
    assign w_lx       = LX_W'(w_dx);
    assign w_addr     = ADDR_W'((32'(w_ly) << LX_W) + 32'(w_lx));

    // Leading-zero blanking; the ones slot is always shown
    assign w_lead_blank[0] = (r_digits[15:12] == 4'd0);
    assign w_lead_blank[1] = w_lead_blank[0] && (r_digits[11:8] == 4'd0);
    assign w_lead_blank[2] = w_lead_blank[1] && (r_digits[7:4] == 4'd0);
    assign w_lead_blank[3] = 1'b0;
    assign w_blank         = w_lead_blank[w_slot];

    // Select the displayed digit for the current slot (slot 0 = thousands)
    always_comb begin
        w_digit = 4'd0;
        case (w_slot)
            2'd0:    w_digit = r_digits[15:12];
            2'd1:    w_digit = r_digits[11:8];
            2'd2:    w_digit = r_digits[7:4];
            default: w_digit = r_digits[3:0];
        endcase
    end

    // Conversion FSM: latch, 14 shift iterations, then commit outside the box rows
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_bin      <= 14'd0;
            r_bcd      <= 16'd0;
            r_cnt      <= 4'd0;
            r_pend_val <= 14'd0;
            r_pend_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_digits   <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (score_load) begin
                        r_bin   <= w_load_val;
                        r_bcd   <= 16'd0;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (score_load) begin
                        r_pend_val <= w_load_val;
                        r_pend_vld <= 1'b1;
                    end
                    if (r_cnt == ITER_LAST) begin
                        r_state <= ST_COMMIT_WAIT;
                    end else begin
                        {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                        r_cnt          <= r_cnt + 4'd1;
                    end
                end
                ST_COMMIT_WAIT: begin
                    if (w_y_in_box) begin
                        // Hold the old digits while the box rows are being drawn
                        if (score_load) begin
                            r_pend_val <= w_load_val;
                            r_pend_vld <= 1'b1;
                        end
                    end else begin
                        r_digits <= r_bcd;
                        if (score_load) begin
                            // A load on the commit edge is the newest value
                            r_bin      <= w_load_val;
                            r_bcd      <= 16'd0;
                            r_cnt      <= 4'd0;
                            r_pend_vld <= 1'b0;
                            r_state    <= ST_SHIFT;
                        end else if (r_pend_vld) begin
                            r_bin      <= r_pend_val;
                            r_bcd      <= 16'd0;
                            r_cnt      <= 4'd0;
                            r_pend_vld <= 1'b0;
                            r_state    <= ST_SHIFT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pixel pipeline: S1 registers ROM address/select, S2 registers ROM colour
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rom_addr  <= '0;
            r_rom_digit <= 4'd0;
            r_vis1      <= 1'b0;
            r_palette   <= 4'd0;
            r_score_on  <= 1'b0;
        end else begin
            r_rom_addr  <= w_in_box ? w_addr : '0;
            r_rom_digit <= w_in_box ? w_digit : 4'd0;
            r_vis1      <= w_in_box && !w_blank;
            r_palette   <= r_vis1 ? rom_index : 4'd0;
            r_score_on  <= r_vis1;
        end
    end

    assign busy          = r_busy;
    assign bcd_digits    = r_digits;
    assign rom_addr      = r_rom_addr;
    assign rom_digit     = r_rom_digit;
    assign palette_index = r_palette;
    assign score_on      = r_score_on;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Bench for score_digit_renderer: directed and random scores/pixels against
// an arithmetic reference model (decimal digits via / and %).
module tb_score_digit_renderer;

    localparam int SX = 560;
    localparam int SY = 16;
    localparam int DW = 16;
    localparam int DH = 24;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [13:0] score_in;
    logic        score_load;
    logic        busy;
    logic [15:0] bcd_digits;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [8:0]  rom_addr;
    logic [3:0]  rom_digit;
    logic [3:0]  rom_index;
    logic [3:0]  palette_index;
    logic        score_on;

    int n_vec = 0;
    int n_err = 0;
    int cur   = 0;

    score_digit_renderer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .score_in     (score_in),
        .score_load   (score_load),
        .busy         (busy),
        .bcd_digits   (bcd_digits),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .rom_addr     (rom_addr),
        .rom_digit    (rom_digit),
        .rom_index    (rom_index),
        .palette_index(palette_index),
        .score_on     (score_on)
    );

    always #5 Clk = ~Clk;

    // Glyph ROM stand-in: arbitrary pattern of address and digit
    function automatic logic [3:0] rom_fn(input int addr, input int digit);
        return 4'((addr * 5 + digit * 11 + (addr >> 3)) % 16);
    endfunction

    assign rom_index = rom_fn(int'(rom_addr), int'(rom_digit));

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int exp_bcd(input int s);
        return ((s / 1000) << 12) | (((s / 100) % 10) << 8) | (((s / 10) % 10) << 4) | (s % 10);
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Probe one pixel through both pipeline stages against the model
    task automatic probe(input int x, input int y);
        int slot, lx, ly, e_addr, e_digit, e_vis, dig;
        bit inb;
        inb = (x >= SX) && (x < SX + 4 * DW) && (y >= SY) && (y < SY + DH);
        e_addr = 0; e_digit = 0; e_vis = 0;
        if (inb) begin
            slot = (x - SX) / DW;
            lx   = (x - SX) % DW;
            ly   = y - SY;
            e_addr = ly * DW + lx;
            case (slot)
                0:       dig = cur / 1000;
                1:       dig = (cur / 100) % 10;
                2:       dig = (cur / 10) % 10;
                default: dig = cur % 10;
            endcase
            e_digit = dig;
            if (slot == 3) e_vis = 1;
            else if (slot == 2) e_vis = (cur >= 10) ? 1 : 0;
            else if (slot == 1) e_vis = (cur >= 100) ? 1 : 0;
            else e_vis = (cur >= 1000) ? 1 : 0;
        end
        DrawX = 10'(x);
        DrawY = 10'(y);
        step();
        chk("rom_addr", int'(rom_addr), e_addr);
        chk("rom_digit", int'(rom_digit), e_digit);
        step();
        chk("score_on", int'(score_on), e_vis);
        chk("palette_index", int'(palette_index),
            e_vis ? int'(rom_fn(e_addr, e_digit)) : 0);
    endtask

    // Load a score with the beam outside the box rows; check latency and digits
    task automatic convert(input int v);
        int guard;
        DrawY = 10'd200;
        score_in = 14'(v);
        score_load = 1'b1;
        step();
        score_load = 1'b0;
        chk("busy_after_load", int'(busy), 1);
        guard = 0;
        while (busy && guard < 64) begin
            step();
            guard++;
        end
        chk("conv_latency", guard, 16);
        cur = sat(v);
        chk("bcd_digits", int'(bcd_digits), exp_bcd(cur));
    endtask

    task automatic scan_slots();
        for (int s = 0; s < 4; s++) begin
            probe(SX + s * DW + $urandom_range(0, DW - 1), SY + $urandom_range(0, DH - 1));
        end
    endtask

    initial begin
        int guard;
        bit seen11, seen22;
        Reset = 1'b1;
        score_in = 14'd0;
        score_load = 1'b0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_bcd", int'(bcd_digits), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_rom_digit", int'(rom_digit), 0);
        chk("rst_palette", int'(palette_index), 0);
        chk("rst_score_on", int'(score_on), 0);
        Reset = 1'b0;
        cur = 0;

        // Score 0: only the ones slot lit; box edges
        scan_slots();
        probe(SX - 1, SY + 4);
        probe(SX + 4 * DW, SY + 4);
        probe(SX + 3 * DW, SY - 1);
        probe(SX + 3 * DW, SY + DH);
        probe(SX + 4 * DW - 1, SY + DH - 1);

        // 1234: exact 16-cycle busy window, then glyph addressing
        convert(1234);
        probe(SX + 17, SY + 2);
        scan_slots();

        convert(16000);
        scan_slots();
        convert(70);
        scan_slots();

        // Commit is held while DrawY is inside the box rows
        DrawY = 10'(SY + 4);
        score_in = 14'd5;
        score_load = 1'b1;
        step();
        score_load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            DrawY = (i < 30) ? 10'(SY + 4) : 10'(SY + DH - 1);
            step();
        end
        chk("hold_busy", int'(busy), 1);
        chk("hold_bcd", int'(bcd_digits), exp_bcd(70));
        DrawY = 10'(SY + DH);
        step();
        chk("release_busy", int'(busy), 0);
        chk("release_bcd", int'(bcd_digits), exp_bcd(5));
        cur = 5;
        scan_slots();

        // Pending register: newest of the loads during a conversion wins
        DrawY = 10'd200;
        score_in = 14'd11;
        score_load = 1'b1;
        step();
        score_load = 1'b0;
        step(); step();
        score_in = 14'd22; score_load = 1'b1; step(); score_load = 1'b0;
        step(); step();
        score_in = 14'd33; score_load = 1'b1; step(); score_load = 1'b0;
        seen11 = 0; seen22 = 0; guard = 0;
        while (busy && guard < 80) begin
            step();
            guard++;
            if (bcd_digits == 16'h0011) seen11 = 1;
            if (bcd_digits == 16'h0022) seen22 = 1;
        end
        chk("pend_cycles", guard, 26);
        chk("pend_seen11", int'(seen11), 1);
        chk("pend_seen22", int'(seen22), 0);
        chk("pend_bcd", int'(bcd_digits), exp_bcd(33));
        cur = 33;

        // Load on the commit edge starts the next conversion directly
        score_in = 14'd100;
        score_load = 1'b1;
        step();
        score_load = 1'b0;
        for (int i = 0; i < 15; i++) step();
        score_in = 14'd4321;
        score_load = 1'b1;
        step();
        score_load = 1'b0;
        chk("commit_load_bcd", int'(bcd_digits), exp_bcd(100));
        chk("commit_load_busy", int'(busy), 1);
        guard = 0;
        while (busy && guard < 64) begin
            step();
            guard++;
        end
        chk("commit_load_cycles", guard, 16);
        chk("commit_load_final", int'(bcd_digits), exp_bcd(4321));
        cur = 4321;

        // Reset in the middle of a conversion aborts it and clears the display
        score_in = 14'd777;
        score_load = 1'b1;
        step();
        score_load = 1'b0;
        step(); step(); step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_bcd", int'(bcd_digits), 0);
        cur = 0;
        for (int i = 0; i < 20; i++) step();
        chk("midrst_idle_bcd", int'(bcd_digits), 0);
        scan_slots();

        // Random scores (including the saturating range) and random pixels
        for (int k = 0; k < 20; k++) begin
            case (k % 4)
                0:       convert(int'($urandom_range(0, 9)));
                1:       convert(int'($urandom_range(10, 999)));
                2:       convert(int'($urandom_range(1000, 9999)));
                default: convert(int'($urandom_range(0, 16383)));
            endcase
            scan_slots();
            for (int p = 0; p < 4; p++) begin
                probe(int'($urandom_range(SX - 8, SX + 4 * DW + 8)),
                      int'($urandom_range(SY - 4, SY + DH + 4)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
